// File: rtl/cpu_control_sequencer.sv
// Control sequencer for the 8-bit accumulator CPU.
// Steps a six-T-state fetch/execute cycle and decodes datapath control lines.
module cpu_control_sequencer #(
    parameter int                    OPCODE_W = 4,
    parameter logic [OPCODE_W-1:0]   OP_LDA   = 4'h0,
    parameter logic [OPCODE_W-1:0]   OP_ADD   = 4'h1,
    parameter logic [OPCODE_W-1:0]   OP_SUB   = 4'h2,
    parameter logic [OPCODE_W-1:0]   OP_OUT   = 4'hE,
    parameter logic [OPCODE_W-1:0]   OP_HLT   = 4'hF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pc_en,
    output logic                pc_inc,
    output logic                mar_load,
    output logic                ram_en,
    output logic                ir_load,
    output logic                ir_en,
    output logic                a_load,
    output logic                a_en,
    output logic                b_load,
    output logic                alu_en,
    output logic                alu_sub,
    output logic                out_load,
    output logic                halted,
    output logic [2:0]          tstate,
    output logic [7:0]          instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t              state, state_next;
    logic [OPCODE_W-1:0] op_q;
    logic [OPCODE_W-1:0] dec_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            instr_count <= 8'd0;
        end else begin
            state <= state_next;
            if (state == S_T4)
                op_q <= opcode;
            if (state == S_T6)
                instr_count <= instr_count + 8'd1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = run ? S_T1 : S_IDLE;
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3:    state_next = S_T4;
            S_T4:    state_next = (opcode == OP_HLT) ? S_HALT : S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = run ? S_T1 : S_IDLE;
            S_HALT:  state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    // T4 sees the live IR; later states use the latched copy so IR changes cannot leak in.
    assign dec_op = (state == S_T4) ? opcode : op_q;

    always_comb begin
        pc_en    = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        ram_en   = 1'b0;
        ir_load  = 1'b0;
        ir_en    = 1'b0;
        a_load   = 1'b0;
        a_en     = 1'b0;
        b_load   = 1'b0;
        alu_en   = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        halted   = 1'b0;
        tstate   = 3'd0;
        case (state)
            S_T1: begin
                tstate   = 3'd1;
                pc_en    = 1'b1;
                mar_load = 1'b1;
            end
            S_T2: begin
                tstate = 3'd2;
                pc_inc = 1'b1;
            end
            S_T3: begin
                tstate  = 3'd3;
                ram_en  = 1'b1;
                ir_load = 1'b1;
            end
            S_T4: begin
                tstate = 3'd4;
                if (dec_op == OP_LDA || dec_op == OP_ADD || dec_op == OP_SUB) begin
                    ir_en    = 1'b1;
                    mar_load = 1'b1;
                end else if (dec_op == OP_OUT) begin
                    a_en     = 1'b1;
                    out_load = 1'b1;
                end
            end
            S_T5: begin
                tstate = 3'd5;
                if (dec_op == OP_LDA) begin
                    ram_en = 1'b1;
                    a_load = 1'b1;
                end else if (dec_op == OP_ADD || dec_op == OP_SUB) begin
                    ram_en = 1'b1;
                    b_load = 1'b1;
                end
            end
            S_T6: begin
                tstate = 3'd6;
                if (dec_op == OP_ADD || dec_op == OP_SUB) begin
                    alu_en  = 1'b1;
                    a_load  = 1'b1;
                    alu_sub = (dec_op == OP_SUB);
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Self-checking bench for cpu_control_sequencer: directed plus randomized cycles
// compared against a cycle-level behavioural model of the fetch/execute sequence.
module tb_cpu_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] opcode;
    logic       pc_en, pc_inc, mar_load, ram_en, ir_load, ir_en;
    logic       a_load, a_en, b_load, alu_en, alu_sub, out_load;
    logic       halted;
    logic [2:0] tstate;
    logic [7:0] instr_count;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: step within the instruction (0 = not executing), halt flag,
    // opcode captured at the end of the decode step, and completed-instruction tally.
    int         m_step;
    bit         m_halt;
    logic [3:0] m_op;
    int         m_count;

    localparam logic [11:0] C_PC_EN  = 12'h800;
    localparam logic [11:0] C_PC_INC = 12'h400;
    localparam logic [11:0] C_MAR    = 12'h200;
    localparam logic [11:0] C_RAM_EN = 12'h100;
    localparam logic [11:0] C_IR_LD  = 12'h080;
    localparam logic [11:0] C_IR_EN  = 12'h040;
    localparam logic [11:0] C_A_LD   = 12'h020;
    localparam logic [11:0] C_A_EN   = 12'h010;
    localparam logic [11:0] C_B_LD   = 12'h008;
    localparam logic [11:0] C_ALU_EN = 12'h004;
    localparam logic [11:0] C_SUB    = 12'h002;
    localparam logic [11:0] C_OUT    = 12'h001;

    cpu_control_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .pc_en       (pc_en),
        .pc_inc      (pc_inc),
        .mar_load    (mar_load),
        .ram_en      (ram_en),
        .ir_load     (ir_load),
        .ir_en       (ir_en),
        .a_load      (a_load),
        .a_en        (a_en),
        .b_load      (b_load),
        .alu_en      (alu_en),
        .alu_sub     (alu_sub),
        .out_load    (out_load),
        .halted      (halted),
        .tstate      (tstate),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] expCtrl(input int step, input logic [3:0] op);
        logic [11:0] v;
        v = 12'h000;
        case (step)
            1: v = C_PC_EN | C_MAR;
            2: v = C_PC_INC;
            3: v = C_RAM_EN | C_IR_LD;
            4: begin
                if (op <= 4'h2)      v = C_IR_EN | C_MAR;
                else if (op == 4'hE) v = C_A_EN | C_OUT;
            end
            5: begin
                if (op == 4'h0)                    v = C_RAM_EN | C_A_LD;
                else if (op == 4'h1 || op == 4'h2) v = C_RAM_EN | C_B_LD;
            end
            6: begin
                if (op == 4'h1)      v = C_ALU_EN | C_A_LD;
                else if (op == 4'h2) v = C_ALU_EN | C_SUB | C_A_LD;
            end
            default: v = 12'h000;
        endcase
        return v;
    endfunction

    task automatic modelReset();
        m_step  = 0;
        m_halt  = 1'b0;
        m_op    = 4'h0;
        m_count = 0;
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelStep();
        if (!rst_n) begin
            modelReset();
        end else if (!m_halt) begin
            if (m_step == 0) begin
                m_step = run ? 1 : 0;
            end else if (m_step == 4 && opcode == 4'hF) begin
                m_halt = 1'b1;
                m_step = 0;
            end else if (m_step == 6) begin
                m_count = (m_count + 1) % 256;
                m_step  = run ? 1 : 0;
            end else begin
                if (m_step == 4) m_op = opcode;
                m_step = m_step + 1;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [11:0] obs_ctrl, exp_ctrl;
        logic [2:0]  exp_t;
        int          drivers;
        obs_ctrl = {pc_en, pc_inc, mar_load, ram_en, ir_load, ir_en,
                    a_load, a_en, b_load, alu_en, alu_sub, out_load};
        exp_ctrl = expCtrl(m_step, (m_step == 4) ? opcode : m_op);
        exp_t    = 3'(m_step);
        drivers  = int'(pc_en) + int'(ram_en) + int'(ir_en) + int'(a_en) + int'(alu_en);

        checks++;
        assert (obs_ctrl === exp_ctrl) else begin
            failures++;
            $error("[TB] FAIL %s ctrl observed=%03h expected=%03h", tag, obs_ctrl, exp_ctrl);
        end
        checks++;
        assert (tstate === exp_t) else begin
            failures++;
            $error("[TB] FAIL %s tstate observed=%0d expected=%0d", tag, tstate, exp_t);
        end
        checks++;
        assert (halted === m_halt) else begin
            failures++;
            $error("[TB] FAIL %s halted observed=%0b expected=%0b", tag, halted, m_halt);
        end
        checks++;
        assert (instr_count === 8'(m_count)) else begin
            failures++;
            $error("[TB] FAIL %s instr_count observed=%0d expected=%0d", tag, instr_count, m_count);
        end
        checks++;
        assert (drivers <= 1) else begin
            failures++;
            $error("[TB] FAIL %s bus_drivers observed=%0d expected<=1", tag, drivers);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] op, input string tag);
        run    = r;
        opcode = op;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        int guard;
        rst_n  = 1'b0;
        run    = 1'b0;
        opcode = 4'h0;
        modelReset();
        #1;
        checkOutput("reset_async");

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'h0, "reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 4'h0, "idle");

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'h0, "lda");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'h1, "add");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, (m_step >= 5) ? 4'h5 : 4'h2, "sub_ir_change");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4'hE, "out");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'hF, "hlt");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "halt_sticky");

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 4'h0, "reset_from_halt");
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'h0, "after_release");

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h0, "run_drop_start");
        guard = 0;
        do begin
            applyStimulus(1'b0, 4'h0, "run_drop");
            guard++;
        end while (m_step != 0 && guard < 10);
        checks++;
        assert (guard < 10) else begin
            failures++;
            $error("[TB] FAIL run_drop_timeout observed=%0d expected<10", guard);
        end
        applyStimulus(1'b0, 4'h0, "run_drop_idle");

        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'h1, "pre_reset_pulse");
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_pulse_async");
        applyStimulus(1'b1, 4'h1, "reset_pulse_held");
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'h1, "reset_pulse_release");

        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 14)), "random");

        rst_n = 1'b0;
        applyStimulus(1'b0, 4'h0, "reset_before_wrap");
        rst_n = 1'b1;
        for (int i = 0; i < 256 * 6; i++) applyStimulus(1'b1, 4'h7, "nop_wrap");
        applyStimulus(1'b0, 4'h7, "nop_wrap_end");
        checks++;
        assert (instr_count === 8'h00) else begin
            failures++;
            $error("[TB] FAIL wrap_count observed=%0d expected=0", instr_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
